// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the configuration master and by the FIR engine's slave port.
// Holds word/timing defaults, the master state encoding and the SPI mode constants.
package spi_pkg;

  localparam int SpiWordWidth  = 16;
  localparam int SpiHalfPeriod = 4;
  localparam int SpiCsGuard    = 2;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam logic SpiCpol = 1'b0;
  localparam logic SpiCpha = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    WAITNEXT = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } spi_master_state_t;

  function automatic logic spi_cs_asserted(input spi_master_state_t s);
    logic r;
    case (s)
      SETUP, SHIFT, WAITNEXT, HOLD: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_clock_gen.sv
// Half-period counter producing the serial clock level plus start-of-low and end-of-high pulses.
// Cleared whenever it is disabled, so every enabled run starts at the beginning of a low phase.
module spi_clock_gen
  import spi_pkg::*;
#(
  parameter int HalfPeriod = SpiHalfPeriod
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic spiClk,
  output logic fallStart,
  output logic bitDone
);

  localparam int CW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Next count/phase: hold cleared while disabled, toggle phase at the end of each half period.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = {CW{1'b0}};
      phase_d = 1'b0;
    end else if (cnt_q == CW'(HalfPeriod - 1)) begin
      cnt_d   = {CW{1'b0}};
      phase_d = !phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Counter and phase registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= {CW{1'b0}};
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign spiClk    = phase_q ^ SpiCpol;
  assign fallStart = en && !phase_q && (cnt_q == {CW{1'b0}});
  assign bitDone   = en && phase_q && (cnt_q == CW'(HalfPeriod - 1));

endmodule

// File: rtl/spi_config_master.sv
// SPI mode-0 initiator: accepts words over valid/ready and shifts them MSB first inside cs-framed
// transactions; mosi is the top bit of the shift register so it holds its value between frames.
module spi_config_master
  import spi_pkg::*;
#(
  parameter int WordWidth  = SpiWordWidth,
  parameter int HalfPeriod = SpiHalfPeriod,
  parameter int CsGuard    = SpiCsGuard
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WordWidth-1:0] txData,
  input  logic                 txValid,
  input  logic                 txLast,
  output logic                 txReady,
  output logic                 busy,
  output logic                 spiClk,
  output logic                 mosi,
  output logic                 cs
);

  localparam int GW = $clog2(CsGuard + 1);
  localparam int BW = $clog2(WordWidth + 1);

  spi_master_state_t    state_q, state_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WordWidth-1:0] shreg_q, shreg_d;
  logic                 last_q, last_d;
  logic                 cs_q, cs_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q, busy_d;
  logic                 accept_s, fall_start_s, bit_done_s, clk_en_s;

  assign accept_s = txValid && tx_ready_q;
  assign clk_en_s = (state_q == SHIFT);

  spi_clock_gen #(.HalfPeriod(HalfPeriod)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (clk_en_s),
    .spiClk    (spiClk),
    .fallStart (fall_start_s),
    .bitDone   (bit_done_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    case (state_q)
      IDLE, WAITNEXT: begin
        if (accept_s) begin
          shreg_d   = txData;
          last_d    = txLast;
          bit_cnt_d = {BW{1'b0}};
          guard_d   = {GW{1'b0}};
          state_d   = (state_q == IDLE) ? SETUP : SHIFT;
        end else begin
          state_d   = state_q;
        end
      end
      SETUP, HOLD, GAP: begin
        if (guard_q == GW'(CsGuard - 1)) begin
          guard_d = {GW{1'b0}};
          case (state_q)
            SETUP:   state_d = SHIFT;
            HOLD:    state_d = GAP;
            default: state_d = IDLE;
          endcase
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      SHIFT: begin
        // bit_cnt counts bits started, so it equals WordWidth during the final bit.
        if (fall_start_s) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (bit_done_s) begin
          if (bit_cnt_q == BW'(WordWidth)) begin
            bit_cnt_d = {BW{1'b0}};
            guard_d   = {GW{1'b0}};
            state_d   = last_q ? HOLD : WAITNEXT;
          end else begin
            shreg_d   = {shreg_q[WordWidth-2:0], 1'b0};
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_d       = !spi_cs_asserted(state_d);
    tx_ready_d = (state_d == IDLE) || (state_d == WAITNEXT);
    busy_d     = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      guard_q    <= {GW{1'b0}};
      bit_cnt_q  <= {BW{1'b0}};
      shreg_q    <= {WordWidth{1'b0}};
      last_q     <= 1'b0;
      cs_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      cs_q       <= cs_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign mosi    = shreg_q[WordWidth-1];
  assign cs      = cs_q;
  assign txReady = tx_ready_q;
  assign busy    = busy_q;

endmodule
